// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port round-robin arbiter/sequencer in front of the byte-
//            addressed data RAM. One request at a time: accept, one RAM
//            access, one response pulse. Handles load extension and flags
//            misaligned / out-of-range requests.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int                        ADDRESS_LENGTH = 32,
    parameter logic [ADDRESS_LENGTH-1:0] ADDR_MAX       = 32'h1FFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      p0_valid,
    output logic                      p0_ready,
    input  logic [ADDRESS_LENGTH-1:0] p0_addr,
    input  logic [ADDRESS_LENGTH-1:0] p0_wdata,
    input  logic [1:0]                p0_size,
    input  logic                      p0_write,
    input  logic                      p0_unsigned,
    output logic                      p0_resp_valid,
    output logic                      p0_resp_err,
    output logic [ADDRESS_LENGTH-1:0] p0_rdata,

    input  logic                      p1_valid,
    output logic                      p1_ready,
    input  logic [ADDRESS_LENGTH-1:0] p1_addr,
    input  logic [ADDRESS_LENGTH-1:0] p1_wdata,
    input  logic [1:0]                p1_size,
    input  logic                      p1_write,
    input  logic                      p1_unsigned,
    output logic                      p1_resp_valid,
    output logic                      p1_resp_err,
    output logic [ADDRESS_LENGTH-1:0] p1_rdata,

    output logic [ADDRESS_LENGTH-1:0] mem_a,
    output logic [ADDRESS_LENGTH-1:0] mem_wd,
    output logic                      mem_sw,
    output logic                      mem_sh,
    output logic                      mem_sb,
    input  logic [ADDRESS_LENGTH-1:0] mem_rd
);

    localparam int c_XW = ADDRESS_LENGTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_rr;        // port preferred on a tie
    logic                      r_gnt;       // port owning the current request
    logic [ADDRESS_LENGTH-1:0] r_addr;
    logic [ADDRESS_LENGTH-1:0] r_wdata;
    logic [1:0]                r_size;
    logic                      r_write;
    logic                      r_unsigned;
    logic                      r_err;
    logic [ADDRESS_LENGTH-1:0] r_rdata;

    logic                      w_idle;
    logic                      w_gnt;
    logic [ADDRESS_LENGTH-1:0] w_addr;
    logic [ADDRESS_LENGTH-1:0] w_wdata;
    logic [1:0]                w_size;
    logic                      w_write;
    logic                      w_unsigned;
    logic [1:0]                w_span;
    logic [c_XW-1:0]           w_last;
    logic                      w_err;
    logic                      w_store;
    logic                      w_resp;
    logic [ADDRESS_LENGTH-1:0] w_load;

    // Arbitration: a lone requester wins, a tie goes to the rr pointer.
    assign w_idle   = (r_state == S_IDLE) & rst_n;
    assign w_gnt    = p1_valid & (~p0_valid | r_rr);
    assign p0_ready = w_idle & p0_valid & ~w_gnt;
    assign p1_ready = w_idle & w_gnt;

    assign w_addr     = w_gnt ? p1_addr     : p0_addr;
    assign w_wdata    = w_gnt ? p1_wdata    : p0_wdata;
    assign w_size     = w_gnt ? p1_size     : p0_size;
    assign w_write    = w_gnt ? p1_write    : p0_write;
    assign w_unsigned = w_gnt ? p1_unsigned : p0_unsigned;

    // Last byte touched, computed one bit wider so the range check cannot wrap.
    assign w_span = (w_size == 2'b10) ? 2'd3 : (w_size == 2'b01) ? 2'd1 : 2'd0;
    assign w_last = {1'b0, w_addr} + {{(c_XW-2){1'b0}}, w_span};
    assign w_err  = (w_size == 2'b11)
                  | ((w_size == 2'b01) & w_addr[0])
                  | ((w_size == 2'b10) & (|w_addr[1:0]))
                  | (w_last > {1'b0, ADDR_MAX});

    // Store strobes are gated by rst_n so a store caught by reset never commits.
    assign w_store = rst_n & (r_state == S_ACCESS) & r_write & ~r_err;
    assign mem_sb  = w_store & (r_size == 2'b00);
    assign mem_sh  = w_store & (r_size == 2'b01);
    assign mem_sw  = w_store & (r_size == 2'b10);
    assign mem_a   = r_addr;
    assign mem_wd  = r_wdata;

    // Response is steered to the granted port only.
    assign w_resp        = (r_state == S_RESP);
    assign p0_resp_valid = w_resp & ~r_gnt;
    assign p1_resp_valid = w_resp &  r_gnt;
    assign p0_resp_err   = p0_resp_valid & r_err;
    assign p1_resp_err   = p1_resp_valid & r_err;
    assign p0_rdata      = p0_resp_valid ? r_rdata : '0;
    assign p1_rdata      = p1_resp_valid ? r_rdata : '0;

    // Select and extend the load lane from the RAM read word.
    always_comb begin
        w_load = mem_rd;
        case (r_size)
            2'b00:   w_load = {{(ADDRESS_LENGTH-8){~r_unsigned & mem_rd[7]}},   mem_rd[7:0]};
            2'b01:   w_load = {{(ADDRESS_LENGTH-16){~r_unsigned & mem_rd[15]}}, mem_rd[15:0]};
            default: w_load = mem_rd;
        endcase
    end

    // Request sequencer: IDLE -> ACCESS -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_gnt      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (p0_valid | p1_valid) begin
                        r_gnt      <= w_gnt;
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        r_size     <= w_size;
                        r_write    <= w_write;
                        r_unsigned <= w_unsigned;
                        r_err      <= w_err;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (r_write | r_err) ? '0 : w_load;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_rr    <= ~r_gnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed-vector bench for dmem_arbiter with a byte RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [31:0] c_AMAX = 32'h1FFFF;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid, p0_ready, p1_ready;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [1:0]  p0_size, p1_size;
    logic        p0_write, p1_write, p0_unsigned, p1_unsigned;
    logic        p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_sw, mem_sh, mem_sb;

    int n_vec;
    int n_err;

    logic [7:0] ram [0:32'h1FFFF];

    dmem_arbiter #(.ADDRESS_LENGTH(32), .ADDR_MAX(32'h1FFFF)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_size(p0_size), .p0_write(p0_write),
        .p0_unsigned(p0_unsigned), .p0_resp_valid(p0_resp_valid),
        .p0_resp_err(p0_resp_err), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_size(p1_size), .p1_write(p1_write),
        .p1_unsigned(p1_unsigned), .p1_resp_valid(p1_resp_valid),
        .p1_resp_err(p1_resp_err), .p1_rdata(p1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_sw(mem_sw), .mem_sh(mem_sh),
        .mem_sb(mem_sb), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM model: little-endian combinational read, store on posedge.
    logic [31:0] w_a1, w_a2, w_a3;
    logic [7:0]  w_b0, w_b1, w_b2, w_b3;
    assign w_a1 = mem_a + 32'd1;
    assign w_a2 = mem_a + 32'd2;
    assign w_a3 = mem_a + 32'd3;
    assign w_b0 = (mem_a <= c_AMAX) ? ram[mem_a[16:0]] : 8'h00;
    assign w_b1 = (w_a1  <= c_AMAX) ? ram[w_a1[16:0]]  : 8'h00;
    assign w_b2 = (w_a2  <= c_AMAX) ? ram[w_a2[16:0]]  : 8'h00;
    assign w_b3 = (w_a3  <= c_AMAX) ? ram[w_a3[16:0]]  : 8'h00;
    assign mem_rd = {w_b3, w_b2, w_b1, w_b0};

    always @(posedge clk) begin
        if (mem_sb | mem_sh | mem_sw) ram[mem_a[16:0]] <= mem_wd[7:0];
        if (mem_sh | mem_sw)          ram[w_a1[16:0]]  <= mem_wd[15:8];
        if (mem_sw) begin
            ram[w_a2[16:0]] <= mem_wd[23:16];
            ram[w_a3[16:0]] <= mem_wd[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on a single port, checked cycle by cycle.
    task automatic req(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic wr, input logic uns,
                       input logic exp_err, input logic [31:0] exp_rd);
        logic [2:0] exp_strb;
        exp_strb = (wr && !exp_err) ?
                   ((size == 2'b10) ? 3'b100 : (size == 2'b01) ? 3'b010 : 3'b001) : 3'b000;
        @(negedge clk);
        if (port == 0) begin
            p0_valid = 1'b1; p0_addr = addr; p0_wdata = wdata;
            p0_size = size; p0_write = wr; p0_unsigned = uns;
        end else begin
            p1_valid = 1'b1; p1_addr = addr; p1_wdata = wdata;
            p1_size = size; p1_write = wr; p1_unsigned = uns;
        end
        #1;
        check("accept_ready", {30'd0, p1_ready, p0_ready}, (port == 0) ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        // Scramble the request after accept: only latched values may be used.
        if (port == 0) begin
            p0_valid = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_size = 2'b11; p0_write = ~wr;
        end else begin
            p1_valid = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_size = 2'b11; p1_write = ~wr;
        end
        @(negedge clk);
        check("access_strobe", {29'd0, mem_sw, mem_sh, mem_sb}, {29'd0, exp_strb});
        check("access_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        check("access_addr", mem_a, addr);
        if (wr) check("access_wd", mem_wd, wdata);
        @(negedge clk);
        check("resp_valid", {30'd0, p1_resp_valid, p0_resp_valid}, (port == 0) ? 32'd1 : 32'd2);
        check("resp_err", {31'd0, (port == 0) ? p0_resp_err : p1_resp_err}, {31'd0, exp_err});
        check("resp_rdata", (port == 0) ? p0_rdata : p1_rdata, exp_rd);
        check("resp_strobe", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i <= 32'h1FFFF; i++) ram[i] = 8'h00;
        rst_n = 1'b0;
        p0_valid = 1'b1; p0_addr = 32'h10000; p0_wdata = 32'h0; p0_size = 2'b10;
        p0_write = 1'b0; p0_unsigned = 1'b0;
        p1_valid = 1'b1; p1_addr = 32'h10000; p1_wdata = 32'h0; p1_size = 2'b10;
        p1_write = 1'b0; p1_unsigned = 1'b0;

        // Reset state, with both ports requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        check("rst_resp", {28'd0, p1_resp_valid, p0_resp_valid, p1_resp_err, p0_resp_err}, 32'd0);
        check("rst_strobe", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word store then load-back.
        req(0, 32'h10000, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
        req(0, 32'h10000, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte and half stores, signed/unsigned loads.
        req(0, 32'h10005, 32'h00000080, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        req(0, 32'h10005, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFFFF80);
        req(0, 32'h10005, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h00000080);
        req(0, 32'h10006, 32'h00008001, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        req(0, 32'h10006, 32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF8001);
        req(0, 32'h10006, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0, 32'h00008001);
        req(0, 32'h10004, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'h80018000);

        // Error cases and range boundary.
        req(0, 32'h10002, 32'h12345678, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0);
        req(0, 32'h20000, 32'h12345678, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0);
        req(0, 32'h10000, 32'h0,        2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
        req(0, 32'h1FFFF, 32'h0,        2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        req(0, 32'h1FFFF, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        req(0, 32'h1FFFC, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
        req(0, 32'h10000, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // Port 1 alone; leaves rr pointing at port 0.
        req(1, 32'h10000, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // Both ports continuously valid: grants alternate 0,1,0,1 every 3 cycles.
        p0_addr = 32'h10000; p0_size = 2'b10; p0_write = 1'b0; p0_unsigned = 1'b0;
        p1_addr = 32'h10004; p1_size = 2'b10; p1_write = 1'b0; p1_unsigned = 1'b0;
        p0_valid = 1'b1; p1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fair_ready", {30'd0, p1_ready, p0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            check("fair_busy", {30'd0, p1_ready, p0_ready}, 32'd0);
            @(negedge clk);
            check("fair_resp", {30'd0, p1_resp_valid, p0_resp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("fair_rdata", (i % 2 == 0) ? p0_rdata : p1_rdata,
                  (i % 2 == 0) ? 32'hDEADBEEF : 32'h80018000);
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(posedge clk); #1;

        // Single requester p1 back-to-back.
        p1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("solo_ready", {30'd0, p1_ready, p0_ready}, 32'd2);
            @(negedge clk);
            check("solo_busy", {30'd0, p1_ready, p0_ready}, 32'd0);
            @(negedge clk);
            check("solo_resp", {30'd0, p1_resp_valid, p0_resp_valid}, 32'd2);
        end
        p1_valid = 1'b0;
        @(posedge clk); #1;

        // Leave rr pointing at port 1, then reset in the middle of a store.
        req(0, 32'h10005, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h00000080);
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h10010; p0_wdata = 32'hCAFEF00D;
        p0_size = 2'b10; p0_write = 1'b1; p0_unsigned = 1'b0;
        #1;
        check("rstacc_ready", {30'd0, p1_ready, p0_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstacc_strobe", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
        @(posedge clk); #1;
        check("rstacc_mem_a", mem_a, 32'd0);
        check("rstacc_mem_wd", mem_wd, 32'd0);
        check("rstacc_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        check("rstacc_resp", {30'd0, p1_resp_valid, p0_resp_valid}, 32'd0);
        p1_valid = 1'b1; p1_addr = 32'h10000; p1_size = 2'b10; p1_write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // rr was reset: tie goes to port 0; the interrupted word was never written.
        req(0, 32'h10010, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h00000000);
        p1_valid = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
